vga_fb_reader: RTL and testbench



---
 rtl/vga_fb_pkg.sv | 20 ++
 rtl/vga_timing.sv | 61 ++++++
 rtl/vga_fb_reader.sv | 98 +++++++++
 tb/tb_vga_fb_reader.sv | 118 +++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: VGA 640x480@60 timing, RGB444 pixel layout and sync polarity shared by the frame-buffer reader.
package vga_fb_pkg;
  localparam int c_h_vis = 640;
  localparam int c_h_fp = 16;
  localparam int c_h_sync = 96;
  localparam int c_h_bp = 48;
  localparam int c_h_tot = c_h_vis + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_v_vis = 480;
  localparam int c_v_fp = 10;
  localparam int c_v_sync = 2;
  localparam int c_v_bp = 33;
  localparam int c_v_tot = c_v_vis + c_v_fp + c_v_sync + c_v_bp;
  localparam int c_nb_cnt = 10;
  localparam int c_nb_rgb = 12;
  localparam int c_nb_col = 4;
  localparam int c_r_lsb = 8;
  localparam int c_g_lsb = 4;
  localparam int c_b_lsb = 0;
  localparam logic c_sync_act = 1'b0;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v scan counters, raw syncs, active flag and frame/row strobes.
// VGA_FB_BORDER_EN adds the outer-ring flag used for the white border.
module vga_timing
  import vga_fb_pkg::*;
#(
  parameter int c_scale_log2 = 3,
  parameter int c_h_vis = vga_fb_pkg::c_h_vis,
  parameter int c_h_fp = vga_fb_pkg::c_h_fp,
  parameter int c_h_sync = vga_fb_pkg::c_h_sync,
  parameter int c_h_bp = vga_fb_pkg::c_h_bp,
  parameter int c_v_vis = vga_fb_pkg::c_v_vis,
  parameter int c_v_fp = vga_fb_pkg::c_v_fp,
  parameter int c_v_sync = vga_fb_pkg::c_v_sync,
  parameter int c_v_bp = vga_fb_pkg::c_v_bp
) (
  input  logic clk,
  input  logic rst_n,
  output logic [c_nb_cnt-c_scale_log2-1:0] col,
  output logic row_adv,
  output logic frame_wrap,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic sof
`ifdef VGA_FB_BORDER_EN
  ,output logic border
`endif
);
  localparam int c_ht = c_h_vis + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_vt = c_v_vis + c_v_fp + c_v_sync + c_v_bp;
  logic [c_nb_cnt-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic h_end, v_end;
  always_comb begin
    h_end = hcnt_q == c_nb_cnt'(c_ht - 1);
    v_end = vcnt_q == c_nb_cnt'(c_vt - 1);
    hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
    vcnt_d = h_end ? (v_end ? '0 : vcnt_q + 1'b1) : vcnt_q;
    col = hcnt_q[c_nb_cnt-1:c_scale_log2];
    row_adv = h_end && &vcnt_q[c_scale_log2-1:0];
    frame_wrap = h_end && v_end;
    active = hcnt_q < c_nb_cnt'(c_h_vis) && vcnt_q < c_nb_cnt'(c_v_vis);
    hsync = (hcnt_q >= c_nb_cnt'(c_h_vis + c_h_fp) && hcnt_q < c_nb_cnt'(c_h_vis + c_h_fp + c_h_sync))
          ? c_sync_act : ~c_sync_act;
    vsync = (vcnt_q >= c_nb_cnt'(c_v_vis + c_v_fp) && vcnt_q < c_nb_cnt'(c_v_vis + c_v_fp + c_v_sync))
          ? c_sync_act : ~c_sync_act;
    sof = hcnt_q == '0 && vcnt_q == '0;
`ifdef VGA_FB_BORDER_EN
    border = active && (hcnt_q == '0 || hcnt_q == c_nb_cnt'(c_h_vis - 1)
                        || vcnt_q == '0 || vcnt_q == c_nb_cnt'(c_v_vis - 1));
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end
endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: scans the frame buffer with 2^c_scale_log2 pixel replication and drives VGA pins.
// VGA_FB_BORDER_EN forces a 1-pixel white ring around the visible area.
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int c_img_cols = 80,
  parameter int c_img_rows = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf = c_nb_rgb,
  parameter int c_scale_log2 = 3,
  parameter int c_h_vis = vga_fb_pkg::c_h_vis,
  parameter int c_h_fp = vga_fb_pkg::c_h_fp,
  parameter int c_h_sync = vga_fb_pkg::c_h_sync,
  parameter int c_h_bp = vga_fb_pkg::c_h_bp,
  parameter int c_v_vis = vga_fb_pkg::c_v_vis,
  parameter int c_v_fp = vga_fb_pkg::c_v_fp,
  parameter int c_v_sync = vga_fb_pkg::c_v_sync,
  parameter int c_v_bp = vga_fb_pkg::c_v_bp
) (
  input  logic clk,
  input  logic rst_n,
  output logic [c_nb_img_pxls-1:0] addrb,
  input  logic [c_nb_buf-1:0] doutb,
  output logic [c_nb_col-1:0] vga_red,
  output logic [c_nb_col-1:0] vga_green,
  output logic [c_nb_col-1:0] vga_blue,
  output logic vga_hsync,
  output logic vga_vsync,
  output logic visible,
  output logic frame_start
);
  logic [c_nb_cnt-c_scale_log2-1:0] col;
  logic row_adv, frame_wrap, active, hsync, vsync, sof, row_last, brd;
  logic [c_nb_img_pxls-1:0] line_base_q, line_base_d, addrb_q, addrb_d;
  logic [c_nb_buf-1:0] rgb_q, rgb_d;
  logic act1_q, hs1_q, vs1_q, sof1_q, brd1_q;
  logic vis_q, hs_q, vs_q, fs_q;
  vga_timing #(
    .c_scale_log2(c_scale_log2),
    .c_h_vis(c_h_vis), .c_h_fp(c_h_fp), .c_h_sync(c_h_sync), .c_h_bp(c_h_bp),
    .c_v_vis(c_v_vis), .c_v_fp(c_v_fp), .c_v_sync(c_v_sync), .c_v_bp(c_v_bp)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .col(col), .row_adv(row_adv), .frame_wrap(frame_wrap),
    .active(active), .hsync(hsync), .vsync(vsync), .sof(sof)
`ifdef VGA_FB_BORDER_EN
    , .border(brd)
`endif
  );
`ifndef VGA_FB_BORDER_EN
  assign brd = 1'b0;
`endif
  // line_base stops at the last stored row so blanking lines cannot push it past the image
  always_comb begin
    row_last = line_base_q == c_nb_img_pxls'((c_img_rows - 1) * c_img_cols);
    line_base_d = frame_wrap ? '0
                : (row_adv && !row_last) ? line_base_q + c_nb_img_pxls'(c_img_cols)
                : line_base_q;
    addrb_d = active ? line_base_q + c_nb_img_pxls'(col) : addrb_q;
    rgb_d = !act1_q ? '0 : brd1_q ? '1 : doutb;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base_q <= '0;
      addrb_q <= '0;
      rgb_q <= '0;
      act1_q <= 1'b0;
      hs1_q <= ~c_sync_act;
      vs1_q <= ~c_sync_act;
      sof1_q <= 1'b0;
      brd1_q <= 1'b0;
      vis_q <= 1'b0;
      hs_q <= ~c_sync_act;
      vs_q <= ~c_sync_act;
      fs_q <= 1'b0;
    end else begin
      line_base_q <= line_base_d;
      addrb_q <= addrb_d;
      rgb_q <= rgb_d;
      act1_q <= active;
      hs1_q <= hsync;
      vs1_q <= vsync;
      sof1_q <= sof;
      brd1_q <= brd;
      vis_q <= act1_q;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
      fs_q <= sof1_q;
    end
  end
  assign addrb = addrb_q;
  assign vga_red = rgb_q[c_r_lsb +: c_nb_col];
  assign vga_green = rgb_q[c_g_lsb +: c_nb_col];
  assign vga_blue = rgb_q[c_b_lsb +: c_nb_col];
  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
  assign visible = vis_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: scoreboard bench on a reduced 8x4-image geometry (64x32 visible, 80x39 total) so whole frames fit.
module tb_vga_fb_reader;
  localparam int hv = 64, hf = 4, hs = 8, hb = 4, ht = hv + hf + hs + hb;
  localparam int vv = 32, vf = 2, vs = 2, vb = 3, vt = vv + vf + vs + vb;
  localparam int fr = ht * vt;
`ifdef VGA_FB_BORDER_EN
  localparam bit c_brd = 1'b1;
`else
  localparam bit c_brd = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [12:0] addrb;
  logic [11:0] doutb;
  logic [3:0] r, g, b;
  logic hsync, vsync, visible, frame_start;
  vga_fb_reader #(
    .c_img_cols(8), .c_img_rows(4), .c_nb_img_pxls(13), .c_nb_buf(12), .c_scale_log2(3),
    .c_h_vis(hv), .c_h_fp(hf), .c_h_sync(hs), .c_h_bp(hb),
    .c_v_vis(vv), .c_v_fp(vf), .c_v_sync(vs), .c_v_bp(vb)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addrb(addrb), .doutb(doutb),
    .vga_red(r), .vga_green(g), .vga_blue(b),
    .vga_hsync(hsync), .vga_vsync(vsync), .visible(visible), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] fbv(input logic [12:0] a);
    return c_brd ? 12'h000 : a[11:0] + 12'hA00;
  endfunction
  assign doutb = fbv(addrb);
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic [15:0] sb[$];
  int mh, mv, cyc, fs_first, fs_second, hs_fall, hs_low, vs_low, white;
  logic [12:0] ma;
  logic prev_hs;
  task automatic restart();
    mh = 0; mv = 0; ma = '0; cyc = 0;
    fs_first = -1; fs_second = -1; hs_fall = -1;
    hs_low = 0; vs_low = 0; white = 0; prev_hs = 1'b1;
    sb.delete();
  endtask
  task automatic run(input int n);
    logic act, edg;
    logic [11:0] px;
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      act = mh < hv && mv < vv;
      if (act) ma = 13'((mv / 8) * 8 + mh / 8);
      edg = act && (mh == 0 || mh == hv - 1 || mv == 0 || mv == vv - 1);
      px = !act ? 12'h000 : (c_brd && edg) ? 12'hFFF : fbv(ma);
      sb.push_back({px, act, !(mh >= hv + hf && mh < hv + hf + hs),
                    !(mv >= vv + vf && mv < vv + vf + vs), mh == 0 && mv == 0});
      @(posedge clk);
      @(negedge clk);
      cyc++;
      chk("addrb", 32'(addrb), 32'(ma));
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        chk("pix", 32'({r, g, b, visible, hsync, vsync, frame_start}), 32'(e));
      end
      if (frame_start) begin
        if (fs_first < 0) fs_first = cyc;
        else if (fs_second < 0) fs_second = cyc;
      end
      if (prev_hs && !hsync && hs_fall < 0) hs_fall = cyc;
      prev_hs = hsync;
      if (cyc >= 2 && cyc < 2 + fr) begin
        hs_low += int'(!hsync);
        vs_low += int'(!vsync);
        white += int'(visible && {r, g, b} == 12'hFFF);
      end
      mh++;
      if (mh == ht) begin
        mh = 0;
        mv = (mv == vt - 1) ? 0 : mv + 1;
      end
    end
  endtask
  task automatic chk_reset(input string pfx);
    chk({pfx, "_addrb"}, 32'(addrb), 0);
    chk({pfx, "_rgb"}, 32'({r, g, b}), 0);
    chk({pfx, "_hsync"}, 32'(hsync), 1);
    chk({pfx, "_vsync"}, 32'(vsync), 1);
    chk({pfx, "_visible"}, 32'(visible), 0);
    chk({pfx, "_fs"}, 32'(frame_start), 0);
  endtask
  initial begin
    restart();
    repeat (10) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    run(2 * fr + 5);
    chk("fs_first", fs_first, 2);
    chk("frame_per", fs_second - fs_first, fr);
    chk("hs_fall", hs_fall, hv + hf + 2);
    chk("hs_low", hs_low, vt * hs);
    chk("vs_low", vs_low, vs * ht);
    chk("white", white, c_brd ? 2 * hv + 2 * vv - 4 : 0);
    run(20 * ht + 25);
    chk("pre_vis", 32'(visible), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    repeat (3) @(negedge clk);
    chk_reset("hold");
    rst_n = 1'b1;
    restart();
    run(300);
    chk("rs_fs", fs_first, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
